// File: rtl/i2c_master_pkg.sv
// rtl/i2c_master_pkg.sv - shared types and line-level helper for the I2C master byte controller
package i2c_master_pkg;

    localparam int QUARTERS = 4;

    typedef enum logic [1:0] {
        CMD_START = 2'b00,
        CMD_STOP  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_READ  = 2'b11
    } i2c_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_STOP,
        ST_WBIT,
        ST_WACK,
        ST_RBIT,
        ST_RACK,
        ST_HOLD
    } i2c_state_t;

    // {scl, sda} for a given quarter of an action. START quarter 0 is not
    // covered here because it keeps whatever SCL level the bus already has.
    function automatic logic [1:0] line_drive(input i2c_state_t st,
                                              input logic [1:0] q,
                                              input logic       bit_val);
        logic [1:0] d;
        d = 2'b11;
        case (st)
            ST_START: begin
                case (q)
                    2'd2:    d = 2'b10;
                    2'd3:    d = 2'b00;
                    default: d = 2'b11;
                endcase
            end
            ST_STOP: begin
                case (q)
                    2'd0:    d = 2'b00;
                    2'd1:    d = 2'b10;
                    default: d = 2'b11;
                endcase
            end
            ST_WBIT, ST_WACK, ST_RBIT, ST_RACK: d = {(q != 2'd0), bit_val};
            default: d = 2'b11;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/i2c_master_byte_ctrl_bit_timer.sv
// rtl/i2c_master_byte_ctrl_bit_timer.sv - quarter-period counter with SCL stretch hold
// Ports: clk, rst (async, active high); run enables counting (cleared when low);
// scl_sync is the synchronized SCL level; quarter is the current quarter index;
// quarter_done strobes on the last cycle of each quarter.
module i2c_bit_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       scl_sync,
    output logic [1:0] quarter,
    output logic       quarter_done
);
    import i2c_master_pkg::*;

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          at_last;
    logic          stretched;

    assign at_last = (cnt == LAST);
    // Quarter 1 cannot end while the responder still holds SCL low; the
    // counter parks on its last count until the released level arrives.
    assign stretched    = (quarter == 2'd1) && !scl_sync;
    assign quarter_done = run && at_last && !stretched;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            quarter <= '0;
        end else if (!run) begin
            cnt     <= '0;
            quarter <= '0;
        end else if (quarter_done) begin
            cnt     <= '0;
            quarter <= (quarter == 2'(QUARTERS - 1)) ? 2'd0 : quarter + 2'd1;
        end else if (!at_last) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master_byte_ctrl.sv
// rtl/i2c_master_byte_ctrl.sv - I2C master byte controller: START/STOP/byte write/byte read
// Ports: clk, rst (async, active high); cmd_valid/cmd_ready/cmd/wr_data/rd_nack
// command handshake; rsp_valid/rsp_data/rsp_ack/rsp_err one-cycle response;
// busy while the bus is owned; scl_i/sda_i bus levels; scl_o/sda_o open-drain
// controls (0 = pull low, 1 = release).
module i2c_master_byte_ctrl
    import i2c_master_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  i2c_cmd_t              cmd,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_nack,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_ack,
    output logic                  rsp_err,
    output logic                  busy,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  scl_o,
    output logic                  sda_o
);
    localparam logic [1:0] LAST_Q   = 2'(QUARTERS - 1);
    localparam logic [1:0] SAMPLE_Q = 2'd2;

    i2c_state_t            state;
    logic [1:0]            scl_ff, sda_ff;
    logic                  scl_sync, sda_sync;
    logic [1:0]            quarter;
    logic                  quarter_done;
    logic                  run;
    logic                  accept;
    logic                  cur_bit;
    logic [DATA_WIDTH-1:0] shift;
    logic [2:0]            bit_cnt;
    logic                  nack_r;
    logic                  sample;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_ff <= 2'b11;
            sda_ff <= 2'b11;
        end else begin
            scl_ff <= {scl_ff[0], scl_i};
            sda_ff <= {sda_ff[0], sda_i};
        end
    end
    assign scl_sync = scl_ff[1];
    assign sda_sync = sda_ff[1];

    assign run    = (state != ST_IDLE) && (state != ST_HOLD);
    assign accept = cmd_valid && cmd_ready;

    i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .scl_sync     (scl_sync),
        .quarter      (quarter),
        .quarter_done (quarter_done)
    );

    // SDA level for the bit currently on the wire.
    always_comb begin
        cur_bit = 1'b1;
        case (state)
            ST_WBIT: cur_bit = shift[DATA_WIDTH-1];
            ST_RACK: cur_bit = nack_r;
            default: cur_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            scl_o     <= 1'b1;
            sda_o     <= 1'b1;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_ack   <= 1'b0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            shift     <= '0;
            bit_cnt   <= '0;
            nack_r    <= 1'b0;
            sample    <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            if (rsp_valid) begin
                cmd_ready <= 1'b1;
            end
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        if (cmd == CMD_START) begin
                            state <= ST_START;
                            sda_o <= 1'b1;
                            busy  <= 1'b1;
                        end else if (state == ST_IDLE) begin
                            // No bus to act on: answer immediately, stay idle.
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            rsp_ack   <= 1'b0;
                        end else if (cmd == CMD_STOP) begin
                            state          <= ST_STOP;
                            {scl_o, sda_o} <= 2'b00;
                        end else if (cmd == CMD_WRITE) begin
                            state          <= ST_WBIT;
                            shift          <= wr_data;
                            bit_cnt        <= 3'(DATA_WIDTH - 1);
                            {scl_o, sda_o} <= {1'b0, wr_data[DATA_WIDTH-1]};
                        end else begin
                            state          <= ST_RBIT;
                            nack_r         <= rd_nack;
                            bit_cnt        <= 3'(DATA_WIDTH - 1);
                            {scl_o, sda_o} <= 2'b01;
                        end
                    end
                end
                default: begin
                    if (quarter_done) begin
                        if (quarter == SAMPLE_Q) begin
                            sample <= sda_sync;
                            if (state == ST_RBIT) begin
                                shift <= {shift[DATA_WIDTH-2:0], sda_sync};
                            end
                        end
                        if (quarter != LAST_Q) begin
                            {scl_o, sda_o} <= line_drive(state, quarter + 2'd1, cur_bit);
                        end else begin
                            case (state)
                                ST_START: begin
                                    state     <= ST_HOLD;
                                    scl_o     <= 1'b0;
                                    rsp_valid <= 1'b1;
                                    rsp_err   <= 1'b0;
                                    rsp_data  <= '0;
                                    rsp_ack   <= 1'b0;
                                end
                                ST_STOP: begin
                                    state          <= ST_IDLE;
                                    {scl_o, sda_o} <= 2'b11;
                                    busy           <= 1'b0;
                                    rsp_valid      <= 1'b1;
                                    rsp_err        <= 1'b0;
                                    rsp_data       <= '0;
                                    rsp_ack        <= 1'b0;
                                end
                                ST_WBIT: begin
                                    if (bit_cnt == 3'd0) begin
                                        state          <= ST_WACK;
                                        {scl_o, sda_o} <= 2'b01;
                                    end else begin
                                        bit_cnt        <= bit_cnt - 3'd1;
                                        shift          <= {shift[DATA_WIDTH-2:0], 1'b0};
                                        {scl_o, sda_o} <= {1'b0, shift[DATA_WIDTH-2]};
                                    end
                                end
                                ST_RBIT: begin
                                    if (bit_cnt == 3'd0) begin
                                        state          <= ST_RACK;
                                        {scl_o, sda_o} <= {1'b0, nack_r};
                                    end else begin
                                        bit_cnt        <= bit_cnt - 3'd1;
                                        {scl_o, sda_o} <= 2'b01;
                                    end
                                end
                                ST_WACK: begin
                                    state     <= ST_HOLD;
                                    scl_o     <= 1'b0;
                                    rsp_valid <= 1'b1;
                                    rsp_err   <= 1'b0;
                                    rsp_data  <= '0;
                                    rsp_ack   <= !sample;
                                end
                                default: begin
                                    state     <= ST_HOLD;
                                    scl_o     <= 1'b0;
                                    rsp_valid <= 1'b1;
                                    rsp_err   <= 1'b0;
                                    rsp_data  <= shift;
                                    rsp_ack   <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// tb/tb_i2c_master_byte_ctrl.sv - directed bench for i2c_master_byte_ctrl with a responder model
module tb_i2c_master_byte_ctrl;
    import i2c_master_pkg::*;

    localparam int         CLK_DIV  = 4;
    localparam int         T_SS     = 4 * CLK_DIV + 1;
    localparam int         T_BYTE   = 36 * CLK_DIV + 1;
    localparam logic [6:0] RSP_ADDR = 7'h22;
    localparam logic [7:0] RSP_TX   = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    i2c_cmd_t   cmd = CMD_START;
    logic [7:0] wr_data = 8'h00;
    logic       rd_nack = 1'b0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_ack, rsp_err, busy;
    logic       scl_i, sda_i, scl_o, sda_o;
    logic       scl_hold = 1'b1;
    logic       sda_drv  = 1'b1;
    logic       scl_w, sda_w;

    assign scl_w = scl_o & scl_hold;
    assign sda_w = sda_o & sda_drv;
    assign scl_i = scl_w;
    assign sda_i = sda_w;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] r_data;
    logic       r_ack, r_err, r_ready;

    // responder state
    int         bit_n = 0;
    logic       is_addr = 1'b0, selected = 1'b0, read_mode = 1'b0;
    logic [7:0] rx = 8'h00, addr_byte = 8'h00, wr_byte = 8'h00;
    logic       master_nack = 1'b0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    int         start_cnt = 0, stop_cnt = 0;

    i2c_master_byte_ctrl #(.CLK_DIV(CLK_DIV), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .wr_data   (wr_data),
        .rd_nack   (rd_nack),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ack   (rsp_ack),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_o     (scl_o),
        .sda_o     (sda_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Responder: samples the wires away from the DUT's clock edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                bit_n = 0; is_addr = 1'b0; selected = 1'b0; read_mode = 1'b0; sda_drv = 1'b1;
            end else if (prev_scl && scl_w && prev_sda && !sda_w) begin
                start_cnt++;
                bit_n = 0; is_addr = 1'b1; selected = 1'b0; read_mode = 1'b0; sda_drv = 1'b1;
            end else if (prev_scl && scl_w && !prev_sda && sda_w) begin
                stop_cnt++;
                bit_n = 0; is_addr = 1'b0; selected = 1'b0; read_mode = 1'b0; sda_drv = 1'b1;
            end else if (!prev_scl && scl_w) begin
                if (bit_n < 8) begin
                    rx = {rx[6:0], sda_w};
                end else if (read_mode && !is_addr) begin
                    master_nack = sda_w;
                    if (sda_w) selected = 1'b0;
                end
                bit_n++;
            end else if (prev_scl && !scl_w) begin
                if (bit_n == 8) begin
                    if (is_addr) begin
                        addr_byte = rx;
                        selected  = (rx[7:1] == RSP_ADDR);
                        read_mode = selected && rx[0];
                        sda_drv   = !selected;
                    end else if (!read_mode) begin
                        if (selected) wr_byte = rx;
                        sda_drv = !selected;
                    end else begin
                        sda_drv = 1'b1;
                    end
                end else if (bit_n == 9) begin
                    bit_n   = 0;
                    is_addr = 1'b0;
                    sda_drv = (read_mode && selected) ? RSP_TX[7] : 1'b1;
                end else if (read_mode && selected && !is_addr && bit_n > 0 && bit_n < 8) begin
                    sda_drv = RSP_TX[7-bit_n];
                end
            end
            prev_scl = scl_w;
            prev_sda = sda_w;
        end
    end

    task automatic send_cmd(input i2c_cmd_t c, input logic [7:0] d, input logic nk);
        int g;
        g = 0;
        @(negedge clk);
        cmd = c; wr_data = d; rd_nack = nk; cmd_valid = 1'b1;
        while (!cmd_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!cmd_ready) check_val("accept_timeout", 0, 1);
        @(posedge clk);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) cmd_valid = 1'b0;
        end while (!rsp_valid && lat < 3000);
        if (!rsp_valid) check_val("rsp_timeout", 0, 1);
        r_data = rsp_data; r_ack = rsp_ack; r_err = rsp_err; r_ready = cmd_ready;
    endtask

    task automatic xact(input string tag, input i2c_cmd_t c, input logic [7:0] d,
                        input logic nk, input int exp_lat);
        int lat;
        send_cmd(c, d, nk);
        wait_rsp(lat);
        check_val({tag, "_lat"}, lat, exp_lat);
        check_val({tag, "_err"}, r_err, 0);
    endtask

    // Hold SCL low across bit 3 until 50 cycles past the nominal end of Q1.
    task automatic stall_bit3();
        int g;
        g = 0;
        while (!(bit_n == 3 && scl_o == 1'b0) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) check_val("stall_sync_timeout", 0, 1);
        scl_hold = 1'b0;
        g = 0;
        while (scl_o == 1'b0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        repeat (CLK_DIV + 49) @(negedge clk);
        scl_hold = 1'b1;
    endtask

    initial begin
        int lat;
        int g;
        int sc;

        repeat (3) @(negedge clk);
        check_val("rst_scl_o", scl_o, 1);
        check_val("rst_sda_o", sda_o, 1);
        check_val("rst_cmd_ready", cmd_ready, 1);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_rsp_data", rsp_data, 0);
        check_val("rst_rsp_ack", rsp_ack, 0);
        check_val("rst_rsp_err", rsp_err, 0);
        check_val("rst_busy", busy, 0);
        rst = 1'b0;

        // illegal WRITE in IDLE
        send_cmd(CMD_WRITE, 8'h44, 1'b0);
        wait_rsp(lat);
        check_val("ill_lat", lat, 1);
        check_val("ill_err", r_err, 1);
        check_val("ill_ready_low", r_ready, 0);
        repeat (3) @(negedge clk);
        check_val("ill_scl", scl_o, 1);
        check_val("ill_sda", sda_o, 1);
        check_val("ill_busy", busy, 0);
        check_val("ill_no_start", start_cnt, 0);

        // START, WRITE 0x44, STOP
        xact("start1", CMD_START, 8'h00, 1'b0, T_SS);
        check_val("start1_busy", busy, 1);
        @(negedge clk);
        check_val("rsp_pulse", rsp_valid, 0);
        check_val("ready_after_rsp", cmd_ready, 1);
        xact("wr44", CMD_WRITE, 8'h44, 1'b0, T_BYTE);
        check_val("wr44_ack", r_ack, 1);
        check_val("wr44_data0", r_data, 0);
        check_val("wr44_addr_seen", addr_byte, 8'h44);
        xact("stop1", CMD_STOP, 8'h00, 1'b0, T_SS);
        @(negedge clk);
        check_val("stop1_busy", busy, 0);
        check_val("t1_starts", start_cnt, 1);
        check_val("t1_stops", stop_cnt, 1);

        // START, WRITE 0x45, READ with NACK
        xact("start2", CMD_START, 8'h00, 1'b0, T_SS);
        xact("wr45", CMD_WRITE, 8'h45, 1'b0, T_BYTE);
        check_val("wr45_ack", r_ack, 1);
        xact("rd", CMD_READ, 8'h00, 1'b1, T_BYTE);
        check_val("rd_data", r_data, 8'hA5);
        check_val("rd_nack_bit", master_nack, 1);
        xact("stop2", CMD_STOP, 8'h00, 1'b0, T_SS);
        check_val("t2_stops", stop_cnt, 2);

        // unacked address, then repeated START
        xact("start3", CMD_START, 8'h00, 1'b0, T_SS);
        xact("wr7e", CMD_WRITE, 8'h7E, 1'b0, T_BYTE);
        check_val("wr7e_ack", r_ack, 0);
        @(negedge clk);
        check_val("wr7e_hold_busy", busy, 1);
        check_val("wr7e_hold_ready", cmd_ready, 1);
        check_val("wr7e_hold_scl", scl_o, 0);
        sc = start_cnt;
        xact("rstart", CMD_START, 8'h00, 1'b0, T_SS);
        check_val("rstart_seen", start_cnt, sc + 1);
        xact("stop3", CMD_STOP, 8'h00, 1'b0, T_SS);

        // clock stretch on bit 3 of a data WRITE
        xact("start4", CMD_START, 8'h00, 1'b0, T_SS);
        xact("wr44b", CMD_WRITE, 8'h44, 1'b0, T_BYTE);
        fork
            xact("wr_stretch", CMD_WRITE, 8'h3C, 1'b0, T_BYTE + 52);
            stall_bit3();
        join
        check_val("stretch_ack", r_ack, 1);
        check_val("stretch_data", wr_byte, 8'h3C);
        xact("stop4", CMD_STOP, 8'h00, 1'b0, T_SS);

        // reset in the middle of a READ
        xact("start5", CMD_START, 8'h00, 1'b0, T_SS);
        xact("wr45b", CMD_WRITE, 8'h45, 1'b0, T_BYTE);
        send_cmd(CMD_READ, 8'h00, 1'b1);
        g = 0;
        do begin
            @(negedge clk);
            cmd_valid = 1'b0;
            g++;
        end while (!(bit_n == 5 && scl_o == 1'b0) && g < 2000);
        check_val("pre_rst_scl_low", scl_o, 0);
        #2 rst = 1'b1;
        #1;
        check_val("mid_rst_scl", scl_o, 1);
        check_val("mid_rst_sda", sda_o, 1);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_ready", cmd_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send_cmd(CMD_WRITE, 8'h44, 1'b0);
        wait_rsp(lat);
        check_val("post_rst_idle_err", r_err, 1);
        check_val("post_rst_idle_lat", lat, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
